// File: rtl/hack_ctrl.sv
// hack_ctrl: two-state (FETCH/EXEC) control unit for a Hack-style CPU.
// It fetches one instruction per FETCH over a req/valid handshake. It decodes
// A- and C-instructions in EXEC and drives the external zx/nx/zy/ny/f/no ALU.
// Results are committed to A, D, data memory and PC at the end of EXEC.
module hack_ctrl #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch
  output logic                  instr_req,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  instr_valid,
  input  logic [BUS_WIDTH-1:0]  instr,
  // ALU interface
  output logic                  alu_zx,
  output logic                  alu_nx,
  output logic                  alu_zy,
  output logic                  alu_ny,
  output logic                  alu_f,
  output logic                  alu_no,
  output logic [BUS_WIDTH-1:0]  alu_x,
  output logic [BUS_WIDTH-1:0]  alu_y,
  input  logic [BUS_WIDTH-1:0]  alu_out,
  input  logic                  alu_zr,
  input  logic                  alu_ng,
  // data memory
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  // register visibility
  output logic [BUS_WIDTH-1:0]  a_reg,
  output logic [BUS_WIDTH-1:0]  d_reg
);

  // Instruction field positions (Hack encoding, low 16 bits of the word).
  localparam int BIT_C    = 15;
  localparam int BIT_A    = 12;
  localparam int COMP_HI  = 11;
  localparam int COMP_LO  = 6;
  localparam int BIT_D1   = 5;
  localparam int BIT_D2   = 4;
  localparam int BIT_D3   = 3;
  localparam int BIT_J1   = 2;
  localparam int BIT_J2   = 1;
  localparam int BIT_J3   = 0;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
  logic [BUS_WIDTH-1:0]  a_q,         a_d;
  logic [BUS_WIDTH-1:0]  d_q,         d_d;
  logic [BUS_WIDTH-1:0]  ir_q,        ir_d;
  logic [5:0]            ctrl_q,      ctrl_d;
  logic                  mem_we_q,    mem_we_d;
  logic                  instr_req_q, instr_req_d;

  logic                  is_c_s;
  logic                  jump_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;

  // Jump evaluation and PC increment for the instruction held in ir_q.
  always_comb begin
    is_c_s   = ir_q[BIT_C];
    pc_inc_s = pc_q + ADDR_WIDTH'(1);
    jump_s   = (ir_q[BIT_J1] & alu_ng) |
               (ir_q[BIT_J2] & alu_zr) |
               (ir_q[BIT_J3] & ~alu_ng & ~alu_zr);
  end

  // Next-state, commit and registered-control computation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    d_d         = d_q;
    ir_d        = ir_q;
    ctrl_d      = ctrl_q;
    mem_we_d    = mem_we_q;
    instr_req_d = instr_req_q;

    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          // Latch the instruction and pre-register the EXEC-cycle controls
          // so they leave the block straight from flops.
          ir_d        = instr;
          state_d     = ST_EXEC;
          instr_req_d = 1'b0;
          if (instr[BIT_C]) begin
            ctrl_d   = instr[COMP_HI:COMP_LO];
            mem_we_d = instr[BIT_D3];
          end else begin
            ctrl_d   = 6'b000000;
            mem_we_d = 1'b0;
          end
        end else begin
          // Stall: everything holds, request stays up.
          state_d     = ST_FETCH;
          instr_req_d = 1'b1;
          ctrl_d      = 6'b000000;
          mem_we_d    = 1'b0;
        end
      end

      ST_EXEC: begin
        state_d     = ST_FETCH;
        instr_req_d = 1'b1;
        ctrl_d      = 6'b000000;
        mem_we_d    = 1'b0;
        if (is_c_s) begin
          if (ir_q[BIT_D1]) begin
            a_d = alu_out;
          end else begin
            a_d = a_q;
          end
          if (ir_q[BIT_D2]) begin
            d_d = alu_out;
          end else begin
            d_d = d_q;
          end
          // Jump target is the A value from before this cycle's commit.
          if (jump_s) begin
            pc_d = a_q[ADDR_WIDTH-1:0];
          end else begin
            pc_d = pc_inc_s;
          end
        end else begin
          a_d  = ir_q;
          pc_d = pc_inc_s;
        end
      end

      default: begin
        state_d     = ST_FETCH;
        instr_req_d = 1'b1;
        ctrl_d      = 6'b000000;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      a_q         <= '0;
      d_q         <= '0;
      ir_q        <= '0;
      ctrl_q      <= 6'b000000;
      mem_we_q    <= 1'b0;
      instr_req_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      d_q         <= d_d;
      ir_q        <= ir_d;
      ctrl_q      <= ctrl_d;
      mem_we_q    <= mem_we_d;
      instr_req_q <= instr_req_d;
    end
  end

  // Output drive: the strobes and ALU controls are forced low while rst is
  // high, so a reset landing in EXEC cannot leak a write.
  always_comb begin
    instr_req = instr_req_q;
    pc        = pc_q;
    alu_zx    = ctrl_q[5] & ~rst;
    alu_nx    = ctrl_q[4] & ~rst;
    alu_zy    = ctrl_q[3] & ~rst;
    alu_ny    = ctrl_q[2] & ~rst;
    alu_f     = ctrl_q[1] & ~rst;
    alu_no    = ctrl_q[0] & ~rst;
    alu_x     = d_q;
    if ((state_q == ST_EXEC) && ir_q[BIT_C] && ir_q[BIT_A]) begin
      alu_y = mem_rdata;
    end else begin
      alu_y = a_q;
    end
    mem_addr  = a_q[ADDR_WIDTH-1:0];
    mem_wdata = alu_out;
    mem_we    = mem_we_q & ~rst;
    a_reg     = a_q;
    d_reg     = d_q;
  end

endmodule

// File: tb/tb_hack_ctrl.sv
// Directed, table-driven bench for hack_ctrl. The bench models the Hack ALU
// and a small combinational-read data RAM around the controller.
module tb_hack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [14:0] pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zr, alu_ng;
  logic [14:0] mem_addr;
  logic [15:0] mem_rdata, mem_wdata;
  logic        mem_we;
  logic [15:0] a_reg, d_reg;

  logic [15:0] mem [0:31];
  logic        mem_clr;
  int          we_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  hack_ctrl #(.BUS_WIDTH(16), .ADDR_WIDTH(15)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .pc(pc), .instr_valid(instr_valid), .instr(instr),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .a_reg(a_reg), .d_reg(d_reg)
  );

  // Hack ALU reference model.
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, oo;
    xx = c[5] ? 16'h0000 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0000 : y;
    yy = c[2] ? ~yy : yy;
    oo = c[1] ? (xx + yy) : (xx & yy);
    oo = c[0] ? ~oo : oo;
    return oo;
  endfunction

  assign alu_out   = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr    = (alu_out == 16'h0000);
  assign alu_ng    = alu_out[15];
  assign mem_rdata = mem[mem_addr[4:0]];

  // Data RAM write port and write-strobe counter.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
    end else if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  typedef struct {
    logic [15:0] instr;
    logic [5:0]  ctrl;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] a;
    logic [15:0] d;
    logic [14:0] pc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Run one instruction from FETCH (called #1 after a rising edge).
  task automatic run_instr(input vec_t v);
    int w0;
    w0          = we_cnt;
    instr       = v.instr;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("exec_req",  {31'd0, instr_req}, 32'd0);
    chk("exec_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, {26'd0, v.ctrl});
    chk("exec_we",   {31'd0, mem_we}, {31'd0, v.we});
    chk("exec_addr", {17'd0, mem_addr}, {17'd0, v.addr});
    if (v.we) chk("exec_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
    @(posedge clk); #1;
    chk("we_cycles", we_cnt - w0, {31'd0, v.we});
    chk("a_reg", {16'd0, a_reg}, {16'd0, v.a});
    chk("d_reg", {16'd0, d_reg}, {16'd0, v.d});
    chk("pc",    {17'd0, pc}, {17'd0, v.pc});
    chk("fetch_req", {31'd0, instr_req}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",   {31'd0, mem_we}, 32'd0);
    chk("rst_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'd0);
    rst     = 1'b0;
    mem_clr = 1'b0;
    chk("rst_pc",  {17'd0, pc}, 32'd0);
    chk("rst_a",   {16'd0, a_reg}, 32'd0);
    chk("rst_d",   {16'd0, d_reg}, 32'd0);
    chk("rst_req", {31'd0, instr_req}, 32'd1);
  endtask

  initial begin
    int w0;
    //          instr     ctrl       we    addr      wdata     a         d         pc
    vecs[0]  = '{16'h0005, 6'b000000, 1'b0, 15'h0000, 16'h0000, 16'h0005, 16'h0000, 15'd1};
    vecs[1]  = '{16'hEC10, 6'b110000, 1'b0, 15'h0005, 16'h0000, 16'h0005, 16'h0005, 15'd2};
    vecs[2]  = '{16'hE7C8, 6'b011111, 1'b1, 15'h0005, 16'h0006, 16'h0005, 16'h0005, 15'd3};
    vecs[3]  = '{16'h000A, 6'b000000, 1'b0, 15'h0005, 16'h0000, 16'h000A, 16'h0005, 15'd4};
    vecs[4]  = '{16'hE301, 6'b001100, 1'b0, 15'h000A, 16'h0000, 16'h000A, 16'h0005, 15'd10};
    vecs[5]  = '{16'hEA90, 6'b101010, 1'b0, 15'h000A, 16'h0000, 16'h000A, 16'h0000, 15'd11};
    vecs[6]  = '{16'hE301, 6'b001100, 1'b0, 15'h000A, 16'h0000, 16'h000A, 16'h0000, 15'd12};
    vecs[7]  = '{16'h0005, 6'b000000, 1'b0, 15'h000A, 16'h0000, 16'h0005, 16'h0000, 15'd13};
    vecs[8]  = '{16'hFC10, 6'b110000, 1'b0, 15'h0005, 16'h0000, 16'h0005, 16'h0006, 15'd14};
    vecs[9]  = '{16'hE7E7, 6'b011111, 1'b0, 15'h0005, 16'h0000, 16'h0007, 16'h0006, 15'd5};
    vecs[10] = '{16'hEE90, 6'b111010, 1'b0, 15'h0007, 16'h0000, 16'h0007, 16'hFFFF, 15'd6};
    vecs[11] = '{16'hE304, 6'b001100, 1'b0, 15'h0007, 16'h0000, 16'h0007, 16'hFFFF, 15'd7};

    instr_valid = 1'b0;
    instr       = 16'h0000;
    mem_clr     = 1'b1;
    do_reset();

    for (int i = 0; i < 12; i++) run_instr(vecs[i]);

    // PC wrap: jump to 0x7FFF, then an A-instruction there increments to 0.
    run_instr('{16'h7FFF, 6'b000000, 1'b0, 15'h0007, 16'h0000, 16'h7FFF, 16'hFFFF, 15'd8});
    run_instr('{16'hEA87, 6'b101010, 1'b0, 15'h7FFF, 16'h0000, 16'h7FFF, 16'hFFFF, 15'h7FFF});
    run_instr('{16'h7FFF, 6'b000000, 1'b0, 15'h7FFF, 16'h0000, 16'h7FFF, 16'hFFFF, 15'h0000});

    // Fetch stall: three cycles without instr_valid, nothing moves.
    instr = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_req", {31'd0, instr_req}, 32'd1);
      chk("stall_pc",  {17'd0, pc}, 32'd0);
      chk("stall_a",   {16'd0, a_reg}, 32'h7FFF);
      chk("stall_d",   {16'd0, d_reg}, 32'hFFFF);
      chk("stall_we",  {31'd0, mem_we}, 32'd0);
    end
    run_instr('{16'h0003, 6'b000000, 1'b0, 15'h7FFF, 16'h0000, 16'h0003, 16'hFFFF, 15'd1});

    // Reset landing in EXEC of M=D+1 (A=5): no write, registers cleared.
    do_reset();
    run_instr('{16'h0005, 6'b000000, 1'b0, 15'h0000, 16'h0000, 16'h0005, 16'h0000, 15'd1});
    w0          = we_cnt;
    instr       = 16'hE7C8;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst         = 1'b1;
    #1;
    chk("mid_rst_we",   {31'd0, mem_we}, 32'd0);
    chk("mid_rst_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_wecnt", we_cnt - w0, 32'd0);
    chk("mid_rst_mem5",  {16'd0, mem[5]}, 32'h0006);
    chk("mid_rst_pc",    {17'd0, pc}, 32'd0);
    chk("mid_rst_a",     {16'd0, a_reg}, 32'd0);
    chk("mid_rst_d",     {16'd0, d_reg}, 32'd0);
    chk("mid_rst_req",   {31'd0, instr_req}, 32'd1);
    run_instr('{16'h0003, 6'b000000, 1'b0, 15'h0000, 16'h0000, 16'h0003, 16'h0000, 15'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
